// File: rtl/pipe_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit ripple slice per stage, carry registered between stages.
// Optional ADD_SAT_EN: saturate the sum on signed overflow (default build wraps modulo 2^WIDTH).
module pipe_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  // Handshake: a beat moves on a rising edge when valid && ready on that side.
  // in_ready = !(out_valid && !out_ready); a stall freezes every slot, bubbles included.

  // Slot 0 holds the captured operands; slot k has chunks 0..k-1 of the sum resolved.
  logic             r_v [0:STAGES];
  logic [WIDTH-1:0] r_a [0:STAGES];
  logic [WIDTH-1:0] r_b [0:STAGES];
  logic [WIDTH-1:0] r_s [0:STAGES];
  logic             r_c [0:STAGES];

  logic [WIDTH-1:0] w_nxt_s [1:STAGES];
  logic             w_nxt_c [1:STAGES];
  logic             w_stall;
  logic             w_a_msb;
  logic             w_b_msb;
  logic             w_s_msb;

  always_comb begin
    logic [CHUNK:0] w_ch;
    w_ch = '0;
    for (int k = 1; k <= STAGES; k++) begin
      w_ch = {1'b0, r_a[k-1][(k-1)*CHUNK +: CHUNK]}
           + {1'b0, r_b[k-1][(k-1)*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, r_c[k-1]};
      w_nxt_s[k] = r_s[k-1];
      w_nxt_s[k][(k-1)*CHUNK +: CHUNK] = w_ch[CHUNK-1:0];
      w_nxt_c[k] = w_ch[CHUNK];
    end
  end

  assign w_stall   = r_v[STAGES] && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = r_v[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= STAGES; k++) begin
        r_v[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
      end
    end else if (!w_stall) begin
      // Subtraction is a + ~b + ~cin, so b and cin are conditioned on entry.
      r_v[0] <= in_valid;
      r_a[0] <= a;
      r_b[0] <= sub ? ~b : b;
      r_s[0] <= '0;
      r_c[0] <= sub ? ~cin : cin;
      for (int k = 1; k <= STAGES; k++) begin
        r_v[k] <= r_v[k-1];
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
        r_s[k] <= w_nxt_s[k];
        r_c[k] <= w_nxt_c[k];
      end
    end
  end

  // With b already inverted for sub, one rule covers both modes: equal input signs, different result sign.
  assign w_a_msb = r_a[STAGES][WIDTH-1];
  assign w_b_msb = r_b[STAGES][WIDTH-1];
  assign w_s_msb = r_s[STAGES][WIDTH-1];
  assign ovf     = (w_a_msb == w_b_msb) && (w_s_msb != w_a_msb);
  assign cout    = r_c[STAGES];

`ifdef ADD_SAT_EN
  assign sum = !ovf   ? r_s[STAGES] :
               w_s_msb ? {1'b0, {(WIDTH-1){1'b1}}} :
                         {1'b1, {(WIDTH-1){1'b0}}};
`else
  assign sum = r_s[STAGES];
`endif

endmodule
